// File: rtl/uart_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_port_arbiter                                             |
// | Brief    : Round-robin share of one simpleuart register port between the |
// |            CPU bus and a FIFO-buffered hardware byte stream.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_port_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
    parameter int          FIFO_AW   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_valid_i,
    output logic               cpu_ready_o,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_wdata_i,
    input  logic [3:0]         cpu_wstrb_i,
    output logic [31:0]        cpu_rdata_o,
    input  logic               strm_valid_i,
    output logic               strm_ready_o,
    input  logic [7:0]         strm_data_i,
    output logic               uart_valid_o,
    input  logic               uart_ready_i,
    output logic [31:0]        uart_addr_o,
    output logic [31:0]        uart_wdata_o,
    output logic [3:0]         uart_wstrb_o,
    input  logic [31:0]        uart_rdata_i,
    output logic [FIFO_AW:0]   fifo_level_o
);

    localparam int               c_DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [31:0]      c_DATA_ADDR = BASE_ADDR + 32'd4;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CPU  = 2'd1;
    localparam logic [1:0] c_ST_STRM = 2'd2;

    logic [1:0]       r_state;
    logic             r_last_grant;
    logic [FIFO_AW:0] r_wptr;
    logic [FIFO_AW:0] r_rptr;
    logic [7:0]       r_mem [c_DEPTH];

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_head;

    assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    // Acceptance looks at full only, so a pop in the same cycle never frees a slot early.
    assign w_push  = strm_valid_i && !w_full;
    assign w_pop   = (r_state == c_ST_STRM) && uart_ready_i;
    assign w_head  = r_mem[r_rptr[FIFO_AW-1:0]];

    assign strm_ready_o = !w_full;
    assign fifo_level_o = r_wptr - r_rptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= strm_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_last_grant <= 1'b1;
            r_wptr       <= '0;
            r_rptr       <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (cpu_valid_i && !w_empty) begin
                        r_state <= r_last_grant ? c_ST_CPU : c_ST_STRM;
                    end else if (cpu_valid_i) begin
                        r_state <= c_ST_CPU;
                    end else if (!w_empty) begin
                        r_state <= c_ST_STRM;
                    end
                end
                c_ST_CPU: begin
                    // A CPU that drops valid early is abandoned without earning fairness credit.
                    if (cpu_valid_i && uart_ready_i) begin
                        r_last_grant <= 1'b0;
                        r_state      <= c_ST_IDLE;
                    end else if (!cpu_valid_i) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_STRM: begin
                    if (uart_ready_i) begin
                        r_last_grant <= 1'b1;
                        r_state      <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        uart_valid_o = 1'b0;
        uart_addr_o  = '0;
        uart_wdata_o = '0;
        uart_wstrb_o = '0;
        cpu_ready_o  = 1'b0;
        cpu_rdata_o  = '0;
        case (r_state)
            c_ST_CPU: begin
                uart_valid_o = cpu_valid_i;
                uart_addr_o  = cpu_addr_i;
                uart_wdata_o = cpu_wdata_i;
                uart_wstrb_o = cpu_wstrb_i;
                cpu_ready_o  = uart_ready_i;
                cpu_rdata_o  = uart_rdata_i;
            end
            c_ST_STRM: begin
                uart_valid_o = 1'b1;
                uart_addr_o  = c_DATA_ADDR;
                uart_wdata_o = {24'b0, w_head};
                uart_wstrb_o = 4'b0001;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_port_arbiter                                          |
// | Brief    : Directed and randomized checks of uart_port_arbiter against a |
// |            queue-based arbitration reference.                            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_uart_port_arbiter;

    localparam logic [31:0] c_BASE = 32'h0100_0000;
    localparam int          c_AW   = 4;
    localparam int          c_DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid_i;
    logic        cpu_ready_o;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [3:0]  cpu_wstrb_i;
    logic [31:0] cpu_rdata_o;
    logic        strm_valid_i;
    logic        strm_ready_o;
    logic [7:0]  strm_data_i;
    logic        uart_valid_o;
    logic        uart_ready_i;
    logic [31:0] uart_addr_o;
    logic [31:0] uart_wdata_o;
    logic [3:0]  uart_wstrb_o;
    logic [31:0] uart_rdata_i;
    logic [c_AW:0] fifo_level_o;

    uart_port_arbiter #(.BASE_ADDR(c_BASE), .FIFO_AW(c_AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_valid_i  (cpu_valid_i),
        .cpu_ready_o  (cpu_ready_o),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_wstrb_i  (cpu_wstrb_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .strm_valid_i (strm_valid_i),
        .strm_ready_o (strm_ready_o),
        .strm_data_i  (strm_data_i),
        .uart_valid_o (uart_valid_o),
        .uart_ready_i (uart_ready_i),
        .uart_addr_o  (uart_addr_o),
        .uart_wdata_o (uart_wdata_o),
        .uart_wstrb_o (uart_wstrb_o),
        .uart_rdata_i (uart_rdata_i),
        .fifo_level_o (fifo_level_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference: owner 0 = nobody, 1 = CPU, 2 = stream; bytes waiting in a queue.
    int         m_own;
    bit         m_last;
    logic [7:0] m_q [$];
    logic [7:0] obs_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        logic [31:0] e_v, e_a, e_d, e_s, e_cr, e_rd;
        if (reset) begin
            m_q.delete();
            m_own  = 0;
            m_last = 1'b1;
        end
        #1;
        e_v = 0; e_a = 0; e_d = 0; e_s = 0; e_cr = 0; e_rd = 0;
        if (m_own == 1) begin
            e_v  = {31'b0, cpu_valid_i};
            e_a  = cpu_addr_i;
            e_d  = cpu_wdata_i;
            e_s  = {28'b0, cpu_wstrb_i};
            e_cr = {31'b0, uart_ready_i};
            e_rd = uart_rdata_i;
        end else if (m_own == 2) begin
            e_v = 1;
            e_a = c_BASE + 32'd4;
            e_d = {24'b0, m_q[0]};
            e_s = 32'h1;
        end
        chk("m_uart_valid", {31'b0, uart_valid_o}, e_v);
        chk("m_uart_addr",  uart_addr_o, e_a);
        chk("m_uart_wdata", uart_wdata_o, e_d);
        chk("m_uart_wstrb", {28'b0, uart_wstrb_o}, e_s);
        chk("m_cpu_ready",  {31'b0, cpu_ready_o}, e_cr);
        chk("m_cpu_rdata",  cpu_rdata_o, e_rd);
        chk("m_level",      {27'b0, fifo_level_o}, m_q.size());
        chk("m_strm_ready", {31'b0, strm_ready_o}, (m_q.size() < c_DEPTH) ? 1 : 0);
        if (uart_valid_o && uart_ready_i && uart_wstrb_o == 4'b0001 && uart_addr_o == c_BASE + 32'd4)
            obs_q.push_back(uart_wdata_o[7:0]);
    endtask

    task automatic tick();
        bit push, pop;
        int nxt;
        @(posedge clk);
        if (!reset) begin
            push = strm_valid_i && (m_q.size() < c_DEPTH);
            pop  = (m_own == 2) && uart_ready_i;
            nxt  = m_own;
            if (m_own == 0) begin
                if (cpu_valid_i && m_q.size() > 0) nxt = m_last ? 1 : 2;
                else if (cpu_valid_i)              nxt = 1;
                else if (m_q.size() > 0)           nxt = 2;
            end else if (m_own == 1) begin
                if (cpu_valid_i && uart_ready_i) begin m_last = 1'b0; nxt = 0; end
                else if (!cpu_valid_i) nxt = 0;
            end else if (uart_ready_i) begin
                m_last = 1'b1;
                nxt = 0;
            end
            m_own = nxt;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(strm_data_i);
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    initial begin
        logic [7:0] sent [$];
        string      exp_s;
        logic [7:0] gch;
        bit         cpu_done;
        int         nsent;
        int         obs_n;
        int         cnt;

        reset = 1'b1;
        cpu_valid_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0; cpu_wstrb_i = 0;
        strm_valid_i = 0; strm_data_i = 0; uart_ready_i = 0; uart_rdata_i = 0;
        m_own = 0; m_last = 1'b1;
        @(negedge clk);

        // Reset state
        settle();
        chk("rst_level", {27'b0, fifo_level_o}, 0);
        chk("rst_sready", {31'b0, strm_ready_o}, 1);
        chk("rst_uvalid", {31'b0, uart_valid_o}, 0);
        chk("rst_cready", {31'b0, cpu_ready_o}, 0);
        tick();
        reset = 1'b0;

        // Single CPU read
        cpu_valid_i = 1; cpu_addr_i = c_BASE; cpu_wdata_i = 0; cpu_wstrb_i = 0;
        uart_ready_i = 1; uart_rdata_i = 32'h68;
        settle();
        chk("rd_c0_uvalid", {31'b0, uart_valid_o}, 0);
        tick();
        settle();
        chk("rd_c1_uvalid", {31'b0, uart_valid_o}, 1);
        chk("rd_c1_cready", {31'b0, cpu_ready_o}, 1);
        chk("rd_c1_rdata", cpu_rdata_o, 32'h68);
        tick();
        cpu_valid_i = 0;
        settle();
        chk("rd_c2_idle", {31'b0, uart_valid_o}, 0);
        tick();

        // Stream burst into a stalled UART
        uart_ready_i = 0;
        obs_q.delete();
        for (int i = 0; i < 16; i++) begin
            strm_valid_i = 1; strm_data_i = 8'h41 + 8'(i);
            cyc();
        end
        strm_data_i = 8'h51;
        settle();
        chk("burst_level16", {27'b0, fifo_level_o}, 16);
        chk("burst_full", {31'b0, strm_ready_o}, 0);
        tick();
        strm_valid_i = 0; uart_ready_i = 1;
        for (int i = 0; i < 40; i++) cyc();
        chk("burst_count", obs_q.size(), 16);
        for (int i = 0; i < 16 && i < obs_q.size(); i++)
            chk($sformatf("burst_byte_%0d", i), {24'b0, obs_q[i]}, 32'h41 + i);
        chk("burst_drained", {27'b0, fifo_level_o}, 0);

        // Tie arbitration after reset
        reset = 1'b1; cyc(); reset = 1'b0;
        exp_s = "-C-S-C-S";
        cpu_valid_i = 1; cpu_addr_i = c_BASE + 32'd8; cpu_wstrb_i = 4'hF; cpu_wdata_i = $urandom;
        uart_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            strm_valid_i = (i < 2); strm_data_i = 8'hA0 + 8'(i);
            settle();
            gch = !uart_valid_o ? 8'h2D : (uart_addr_o == c_BASE + 32'd4 ? 8'h53 : 8'h43);
            chk($sformatf("tie_%0d", i), {24'b0, gch}, {24'b0, exp_s[i]});
            tick();
        end
        cpu_valid_i = 0; strm_valid_i = 0;
        cyc();

        // Busy UART holds the stream grant while the CPU waits
        uart_ready_i = 0;
        strm_valid_i = 1; strm_data_i = 8'h77;
        cyc();
        strm_valid_i = 0;
        cyc();
        cpu_valid_i = 1; cpu_addr_i = c_BASE + 32'd8;
        for (int i = 0; i < 100; i++) begin
            settle();
            if (i == 0 || i == 99) begin
                chk("busy_cready", {31'b0, cpu_ready_o}, 0);
                chk("busy_level", {27'b0, fifo_level_o}, 1);
            end
            tick();
        end
        uart_ready_i = 1;
        settle();
        chk("busy_rel_strm", uart_addr_o, c_BASE + 32'd4);
        chk("busy_rel_byte", uart_wdata_o, 32'h77);
        tick();
        settle();
        chk("busy_gap", {31'b0, uart_valid_o}, 0);
        tick();
        settle();
        chk("busy_cpu_done", {31'b0, cpu_ready_o}, 1);
        tick();
        cpu_valid_i = 0;
        cyc();

        // Reset in the middle of a stream transfer
        uart_ready_i = 0;
        for (int i = 0; i < 5; i++) begin
            strm_valid_i = 1; strm_data_i = 8'(i);
            cyc();
        end
        strm_valid_i = 0;
        settle();
        chk("mid_level5", {27'b0, fifo_level_o}, 5);
        chk("mid_valid", {31'b0, uart_valid_o}, 1);
        obs_n = obs_q.size();
        reset = 1'b1;
        settle();
        chk("mid_rst_valid", {31'b0, uart_valid_o}, 0);
        chk("mid_rst_level", {27'b0, fifo_level_o}, 0);
        chk("mid_rst_nopop", obs_q.size(), obs_n);
        tick();
        reset = 1'b0;

        // Randomized traffic through pointer wrap
        obs_q.delete();
        nsent = 0; cnt = 0; cpu_done = 1'b1;
        while ((nsent < 40 || obs_q.size() < 40) && cnt < 3000) begin
            strm_valid_i = (nsent < 40) && ($urandom_range(1, 0) == 1);
            strm_data_i  = 8'($urandom);
            uart_ready_i = ($urandom_range(2, 0) != 0);
            uart_rdata_i = $urandom;
            if (!cpu_valid_i || cpu_done) begin
                cpu_valid_i = ($urandom_range(3, 0) == 0);
                cpu_addr_i  = c_BASE;
                cpu_wdata_i = $urandom;
                cpu_wstrb_i = 4'($urandom);
            end
            if (strm_valid_i && m_q.size() < c_DEPTH) begin
                sent.push_back(strm_data_i);
                nsent++;
            end
            cpu_done = (m_own == 1) && cpu_valid_i && uart_ready_i;
            settle();
            chk("wrap_le16", {31'b0, (fifo_level_o <= 5'd16)}, 1);
            tick();
            cnt++;
        end
        chk("wrap_finished", {31'b0, (cnt < 3000)}, 1);
        chk("wrap_count", obs_q.size(), sent.size());
        for (int i = 0; i < sent.size() && i < obs_q.size(); i++)
            chk($sformatf("wrap_byte_%0d", i), {24'b0, obs_q[i]}, {24'b0, sent[i]});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_port_arbiter.md
# uart_port_arbiter

Shares the single memory-mapped port of the `simpleuart` register interface between two requesters: the CPU bus and a hardware byte stream. The hardware byte stream is, for example, coil telemetry. Stream bytes are buffered in an internal FIFO and drained as data-register writes. A round-robin FSM grants one requester at a time and holds the grant until the UART port completes the transfer. The block sits between the SoC bus decode and `interface_simpleuart`.

## Interface
- `BASE_ADDR`, default 32'h1000000: UART base address. The data register is at BASE_ADDR+4.
- `FIFO_AW`, default 4: stream FIFO address width. Depth = 2^FIFO_AW entries of 8 bits.

- `clk` input 1: sole clock.
- `reset` input 1: asynchronous, active-high reset.
- `cpu_valid_i` input 1: CPU request. Already address-qualified upstream. Held until `cpu_ready_o`.
- `cpu_ready_o` output 1: CPU transfer complete.
- `cpu_addr_i` input 32: CPU address.
- `cpu_wdata_i` input 32: CPU write data.
- `cpu_wstrb_i` input 4: CPU byte strobes. 0 means read.
- `cpu_rdata_o` output 32: CPU read data.
- `strm_valid_i` input 1: stream byte offered.
- `strm_ready_o` output 1: stream byte accepted when `strm_valid_i` is also high.
- `strm_data_i` input 8: stream byte.
- `uart_valid_o` output 1: to the UART port's mem_valid_i.
- `uart_ready_i` input 1: from the UART port's mem_ready_o.
- `uart_addr_o` output 32: UART address.
- `uart_wdata_o` output 32: UART write data.
- `uart_wstrb_o` output 4: UART byte strobes.
- `uart_rdata_i` input 32: UART read data.
- `fifo_level_o` output FIFO_AW+1: current FIFO occupancy.

## Operation
- **FIFO:** 2^FIFO_AW × 8 bits, write and read pointers of FIFO_AW+1 bits.
  - Full when the pointer MSBs differ and the lower bits are equal.
  - `strm_ready_o = !full`, combinational. It depends on full only, so when full, a same-cycle pop does not allow a push.
  - Push on `strm_valid_i && strm_ready_o`.
  - `fifo_level_o` = write pointer − read pointer, modulo 2^(FIFO_AW+1).
- **FSM states:** IDLE, CPU_XFER, STRM_XFER. A register `last_grant` holds 0 for CPU and 1 for stream.
- **IDLE:**
  - Requests are `cpu_req = cpu_valid_i` and `strm_req = !empty`.
  - With exactly one request, go to that requester's XFER state.
  - With both requests, grant the requester that is not `last_grant`.
  - With no request, stay in IDLE.
  - All uart_* outputs are 0 in IDLE.
- **CPU_XFER:** combinational pass-through.
  - `uart_valid_o = cpu_valid_i`.
  - `uart_addr_o`, `uart_wdata_o` and `uart_wstrb_o` equal the corresponding cpu_* inputs.
  - `cpu_ready_o = uart_ready_i`, `cpu_rdata_o = uart_rdata_i`.
  - On `uart_ready_i`: set `last_grant` to 0 and go to IDLE.
  - If `cpu_valid_i` falls before ready (protocol violation), go to IDLE without updating `last_grant`.
- **STRM_XFER:**
  - Drive `uart_valid_o = 1`, `uart_addr_o = BASE_ADDR+4`, `uart_wdata_o = {24'b0, fifo head}`, `uart_wstrb_o = 4'b0001`.
  - On `uart_ready_i`: pop the FIFO, set `last_grant` to 1, go to IDLE.
  - While the UART is busy transmitting, `uart_ready_i` stays low. The grant is held and the CPU waits.
- Outside CPU_XFER, `cpu_ready_o` = 0 and `cpu_rdata_o` = 0.

## Timing
- **Reset values:**
  - State IDLE; `last_grant` = 1, so the CPU wins the first tie.
  - FIFO empty: `fifo_level_o` = 0, `strm_ready_o` = 1.
  - All uart_* outputs = 0; `cpu_ready_o` = 0; `cpu_rdata_o` = 0.
  - Reset asserted mid-transfer drops `uart_valid_o` immediately, discards FIFO contents, and aborts any CPU transfer with no ready pulse.
- **CPU latency:** `cpu_valid_i` is sampled in IDLE at edge N. The UART sees the request from cycle N+1, and `cpu_ready_o` is asserted at the earliest in cycle N+1.
- **Back-to-back:** every transfer returns to IDLE for one cycle. The sustained rate is one transfer per 2 cycles when the UART is not busy.
- **Pointer wrap:** the FIFO pointers wrap modulo 2^(FIFO_AW+1).
- **Simultaneous push and pop:** when not full, both occur and the level is unchanged.
- **Fairness:** `last_grant` updates only on completed transfers. With continuous requests from both sides, grants strictly alternate.

## Test plan
- **Single CPU read:** reset, then `cpu_valid_i` = 1 with addr 0x1000000, wstrb 0, UART model returning ready with rdata 0x00000068. Required: `uart_valid_o` rises in cycle 1; `cpu_ready_o` = 1 with `cpu_rdata_o` = 0x68 in cycle 1; state IDLE in cycle 2.
- **Stream burst and FIFO full:** push 0x41..0x50 (16 bytes) while the UART holds ready low. Required: `fifo_level_o` = 16 and `strm_ready_o` = 0; a 17th byte is not accepted. Then release ready: 16 writes to 0x1000004 with wdata 0x41..0x50 in order, wstrb 0001 each.
- **Tie arbitration:** after reset, assert the CPU request and the stream (FIFO non-empty) together. Required grant order CPU, stream, CPU, stream with `uart_valid_o` gaps of exactly one cycle.
- **Busy UART hold:** in STRM_XFER, hold `uart_ready_i` low for 100 cycles while the CPU requests. Required: `cpu_ready_o` stays 0 and the stream byte is not popped. Release: the stream write completes first, then the CPU transfer.
- **Reset mid-transfer:** assert `reset` during STRM_XFER with level 5. Required: `uart_valid_o` = 0 in the same cycle and `fifo_level_o` = 0; no pop is reported.
- **Wrap:** push and pop 40 bytes through a depth-16 FIFO. Required: output order matches input order across pointer wrap and `fifo_level_o` never exceeds 16.
